// File: rtl/sap1_pkg.sv
// Shared definitions for the SAP-1 controller/sequencer: opcodes, control-word
// bit positions, named control words and the timing-state enum.
package sap1_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Control word bit positions, MSB first
    localparam int CON_CP   = 11;
    localparam int CON_EP   = 10;
    localparam int CON_LM_N = 9;
    localparam int CON_CE_N = 8;
    localparam int CON_LI_N = 7;
    localparam int CON_EI_N = 6;
    localparam int CON_LA_N = 5;
    localparam int CON_EA   = 4;
    localparam int CON_SU   = 3;
    localparam int CON_EU   = 2;
    localparam int CON_LB_N = 1;
    localparam int CON_LO_N = 0;

    localparam logic [11:0] CON_IDLE   = 12'h3E3;
    localparam logic [11:0] CON_T1     = 12'h5E3;
    localparam logic [11:0] CON_T2     = 12'hBE3;
    localparam logic [11:0] CON_T3     = 12'h263;
    localparam logic [11:0] CON_MAR_IR = 12'h1A3;
    localparam logic [11:0] CON_LDA_T5 = 12'h2C3;
    localparam logic [11:0] CON_ALU_T5 = 12'h2E1;
    localparam logic [11:0] CON_ADD_T6 = 12'h3C7;
    localparam logic [11:0] CON_SUB_T6 = 12'h3CF;
    localparam logic [11:0] CON_OUT_T4 = 12'h3F2;

    typedef enum logic [2:0] {
        ST_T1,
        ST_T2,
        ST_T3,
        ST_T4,
        ST_T5,
        ST_T6,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        I_NOP,
        I_LDA,
        I_ADD,
        I_SUB,
        I_OUT,
        I_HLT
    } instr_t;

    // An all-zero ring is HALT; any other non-one-hot value is treated as T1,
    // matching where the ring itself recovers to on the next edge.
    function automatic state_t decode_ring(input logic [5:0] ring);
        state_t st;
        case (ring)
            6'b000001: st = ST_T1;
            6'b000010: st = ST_T2;
            6'b000100: st = ST_T3;
            6'b001000: st = ST_T4;
            6'b010000: st = ST_T5;
            6'b100000: st = ST_T6;
            6'b000000: st = ST_HALT;
            default:   st = ST_T1;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/ring_counter.sv
// Six-bit one-hot timing ring. hold parks the ring at all-zero (HALT) until CLR;
// a corrupted ring falls back to T1 on the next edge.
module ring_counter (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       hold,
    output logic [5:0] tstate
);

    always_ff @(posedge CLK) begin
        if (CLR) begin
            tstate <= 6'b000001;
        end else if (hold) begin
            tstate <= 6'b000000;
        end else if ($onehot(tstate)) begin
            tstate <= {tstate[4:0], tstate[5]};
        end else begin
            tstate <= 6'b000001;
        end
    end

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 controller/sequencer: timing ring plus opcode decode and control-word ROM.
//
//   state | meaning
//   ------+----------------------------------------------
//   T1    | address state, PC onto bus into MAR
//   T2    | increment PC
//   T3    | memory state, RAM into IR
//   T4    | execute 1 (operand address / OUT / HLT check)
//   T5    | execute 2
//   T6    | execute 3
//   HALT  | stopped, waits for CLR
module controller_sequencer
    import sap1_pkg::*;
#(
    parameter int OPCODE_WIDTH = 4,
    parameter int CON_WIDTH    = 12
) (
    input  logic                    CLK,
    input  logic                    CLR,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    output logic [CON_WIDTH-1:0]    CON,
    output logic                    HLT,
    output logic [5:0]              tstate
);

    state_t      state;
    instr_t      instr;
    logic [11:0] con_word;
    logic        halt;

    ring_counter u_ring (
        .CLK    (CLK),
        .CLR    (CLR),
        .hold   (halt),
        .tstate (tstate)
    );

    assign state = decode_ring(tstate);

    always_comb begin
        instr = I_NOP;
        if (opcode == OPCODE_WIDTH'(OP_LDA)) begin
            instr = I_LDA;
        end else if (opcode == OPCODE_WIDTH'(OP_ADD)) begin
            instr = I_ADD;
        end else if (opcode == OPCODE_WIDTH'(OP_SUB)) begin
            instr = I_SUB;
        end else if (opcode == OPCODE_WIDTH'(OP_OUT)) begin
            instr = I_OUT;
        end else if (opcode == OPCODE_WIDTH'(OP_HLT)) begin
            instr = I_HLT;
        end
    end

    // Fetch words ignore the opcode entirely since IR is not loaded until T3.
    always_comb begin
        con_word = CON_IDLE;
        halt     = 1'b0;
        case (state)
            ST_T1: con_word = CON_T1;
            ST_T2: con_word = CON_T2;
            ST_T3: con_word = CON_T3;
            ST_T4: begin
                case (instr)
                    I_LDA, I_ADD, I_SUB: con_word = CON_MAR_IR;
                    I_OUT:               con_word = CON_OUT_T4;
                    I_HLT:               halt     = 1'b1;
                    default:             con_word = CON_IDLE;
                endcase
            end
            ST_T5: begin
                case (instr)
                    I_LDA:        con_word = CON_LDA_T5;
                    I_ADD, I_SUB: con_word = CON_ALU_T5;
                    default:      con_word = CON_IDLE;
                endcase
            end
            ST_T6: begin
                case (instr)
                    I_ADD:   con_word = CON_ADD_T6;
                    I_SUB:   con_word = CON_SUB_T6;
                    default: con_word = CON_IDLE;
                endcase
            end
            ST_HALT: halt = 1'b1;
            default: con_word = CON_IDLE;
        endcase
    end

    assign CON = CON_WIDTH'(con_word);
    assign HLT = halt;

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed and random stimulus for controller_sequencer with a reference
// model feeding an expected-output queue.
module tb_controller_sequencer;

    logic        CLK;
    logic        CLR;
    logic [3:0]  opcode;
    logic [11:0] CON;
    logic        HLT;
    logic [5:0]  tstate;

    typedef struct {
        logic [11:0] con;
        logic        hlt;
        logic [5:0]  ts;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   m_st     = 0;   // model state: 0..5 = T1..T6, 6 = HALT

    controller_sequencer #(.OPCODE_WIDTH(4), .CON_WIDTH(12)) dut (
        .CLK    (CLK),
        .CLR    (CLR),
        .opcode (opcode),
        .CON    (CON),
        .HLT    (HLT),
        .tstate (tstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [11:0] model_con(input int st, input logic [3:0] op);
        case (st)
            0: return 12'h5E3;
            1: return 12'hBE3;
            2: return 12'h263;
            3: case (op)
                   4'h0, 4'h1, 4'h2: return 12'h1A3;
                   4'hE:             return 12'h3F2;
                   default:          return 12'h3E3;
               endcase
            4: case (op)
                   4'h0:       return 12'h2C3;
                   4'h1, 4'h2: return 12'h2E1;
                   default:    return 12'h3E3;
               endcase
            5: case (op)
                   4'h1:    return 12'h3C7;
                   4'h2:    return 12'h3CF;
                   default: return 12'h3E3;
               endcase
            default: return 12'h3E3;
        endcase
    endfunction

    function automatic int model_next(input int st, input logic [3:0] op, input logic clr);
        if (clr) return 0;
        if (st == 6) return 6;
        if (st == 3 && op == 4'hF) return 6;
        return (st + 1) % 6;
    endfunction

    function automatic int drivers(input logic [11:0] c);
        return int'(c[10]) + int'(!c[8]) + int'(!c[6]) + int'(c[4]) + int'(c[2]);
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pop and compare at the falling edge, then move to just after the next rising edge.
    task automatic cycle_chk();
        exp_t e;
        @(negedge CLK);
        e = exp_q.pop_front();
        check({e.tag, "_con"}, CON, e.con);
        check({e.tag, "_hlt"}, {11'd0, HLT}, {11'd0, e.hlt});
        check({e.tag, "_ts"}, {6'd0, tstate}, {6'd0, e.ts});
        check({e.tag, "_cp_ep"}, {11'd0, CON[11] & CON[10]}, 12'd0);
        check({e.tag, "_bus"}, {11'd0, drivers(CON) > 1}, 12'd0);
        check({e.tag, "_ts_legal"}, {11'd0, $onehot0(tstate)}, 12'd1);
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic clr, input string tag);
        exp_t e;
        opcode = op;
        CLR    = clr;
        e.con  = model_con(m_st, op);
        e.hlt  = (m_st == 6) || (m_st == 3 && op == 4'hF);
        e.ts   = (m_st < 6) ? 6'(1 << m_st) : 6'b000000;
        e.tag  = tag;
        exp_q.push_back(e);
        cycle_chk();
        m_st = model_next(m_st, op, clr);
    endtask

    // Opcode is scrambled during fetch to show T1..T3 ignore it.
    task automatic run_instr(input logic [3:0] op, input string tag);
        for (int i = 0; i < 6; i++) begin
            drive((i < 3) ? 4'($urandom_range(0, 15)) : op, 1'b0,
                  $sformatf("%s_t%0d", tag, i + 1));
        end
    endtask

    initial begin
        CLR    = 1'b1;
        opcode = 4'h0;
        @(posedge CLK);
        #1;
        m_st = 0;

        drive(4'h0, 1'b1, "rst_hold1");
        drive(4'h5, 1'b1, "rst_hold2");

        run_instr(4'h0, "lda");
        run_instr(4'h1, "add");
        run_instr(4'h2, "sub");
        run_instr(4'hE, "out");
        run_instr(4'h7, "nop7");
        drive(4'h0, 1'b0, "nop7_resume");
        drive(4'h0, 1'b0, "nop7_resume_t2");
        drive(4'h0, 1'b0, "nop7_resume_t3");
        drive(4'h1, 1'b0, "clr_add_t4");
        drive(4'h1, 1'b1, "clr_add_t5");
        drive(4'h1, 1'b0, "clr_add_after");

        drive(4'h3, 1'b0, "hlt_t2");
        drive(4'h9, 1'b0, "hlt_t3");
        drive(4'hF, 1'b0, "hlt_t4");
        for (int i = 0; i < 20; i++) begin
            drive(4'($urandom_range(0, 15)), 1'b0, $sformatf("halt_%0d", i));
        end
        CLR = 1'b1;
        #2;
        CLR = 1'b0;
        drive(4'h0, 1'b0, "halt_glitch");
        drive(4'h0, 1'b1, "halt_clr");
        drive(4'h0, 1'b0, "after_halt_t1");

        CLR = 1'b1;
        #2;
        CLR = 1'b0;
        drive(4'h0, 1'b0, "glitch_t2");

        for (int i = 0; i < 1000; i++) begin
            logic       clr;
            logic [3:0] op;
            op  = 4'($urandom_range(0, 15));
            clr = (m_st == 6) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 63) == 0);
            drive(op, clr, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/controller_sequencer.md
CONTROLLER_SEQUENCER -- requirements
Module: controller_sequencer

Interface
REQ-001 Parameter OPCODE_WIDTH, default 4: width of the opcode input.
REQ-002 Parameter CON_WIDTH, default 12: width of the control word.
REQ-003 Port CLK, input, 1: the single clock; all state updates occur on the rising edge.
REQ-004 Port CLR, input, 1: reset, synchronous and active-high.
REQ-005 Port opcode, input, OPCODE_WIDTH: upper nibble of the instruction register, valid from T4 onward.
REQ-006 Port CON, output, CON_WIDTH: control word, MSB to LSB Cp Ep Lm_n CE_n Li_n Ei_n La_n Ea Su Eu Lb_n Lo_n.
REQ-007 Port HLT, output, 1: halt request to the clock gate.
REQ-008 Port tstate, output, 6: one-hot timing state T1..T6, bit0 = T1; all-zero in HALT.

Function
REQ-009 The state machine SHALL have states T1, T2, T3, T4, T5, T6 and HALT.
REQ-010 The state machine SHALL advance T1->T2->T3->T4->T5->T6->T1, one state per CLK edge.
REQ-011 From T4 with opcode=HLT (4'hF), the next state SHALL be HALT.
REQ-012 HALT SHALL be held until CLR is asserted.
REQ-013 CON SHALL be combinational from state and opcode, valid for the whole state cycle, with zero latency.
REQ-014 The inactive control word SHALL be 12'h3E3.
REQ-015 Fetch states, independent of opcode: T1 (address state) SHALL drive 12'h5E3, T2 (increment) 12'hBE3, T3 (memory) 12'h263.
REQ-016 LDA (4'h0) SHALL drive T4 12'h1A3, T5 12'h2C3, T6 12'h3E3.
REQ-017 ADD (4'h1) SHALL drive T4 12'h1A3, T5 12'h2E1, T6 12'h3C7.
REQ-018 SUB (4'h2) SHALL drive T4 12'h1A3, T5 12'h2E1, T6 12'h3CF.
REQ-019 OUT (4'hE) SHALL drive T4 12'h3F2, T5 12'h3E3, T6 12'h3E3.
REQ-020 Any undefined opcode SHALL be a NOP: 12'h3E3 in T4–T6, and the machine SHALL continue to T1.
REQ-021 HLT SHALL be 1 in T4 when opcode=HLT and in HALT, and 0 otherwise.
REQ-022 CON SHALL be 12'h3E3 in T4 when opcode=HLT and in HALT.
REQ-023 Ep and Cp SHALL never both be 1, and at most one bus driver (Ep, CE_n low, Ei_n low, Ea, Eu) SHALL be active per state.
REQ-024 Opcode changes during T1–T3 SHALL NOT affect CON.
REQ-025 A non-one-hot internal ring value SHALL recover to T1 on the next edge.

Reset
REQ-026 CLR=1 sampled at a CLK edge SHALL force state T1 from any state, including HALT and mid-instruction.
REQ-027 While CLR is held high, the state SHALL remain T1.
REQ-028 After reset, the outputs SHALL be CON=12'h5E3, HLT=0 and tstate=6'b000001.
REQ-029 Reset has no asynchronous path; CLR changes between edges SHALL have no effect.

Structure
REQ-030 A shared package sap1_pkg SHALL hold:
- the opcode constants (LDA, ADD, SUB, OUT, HLT);
- the CON bit-index constants;
- the named control-word constants (CON_IDLE, CON_T1, CON_T2, CON_T3, ...);
- the state enum.
REQ-031 One sub-module, ring_counter, SHALL implement the 6-bit one-hot ring, with inputs CLK, CLR and hold and output tstate.
REQ-032 The opcode decode and the control-word ROM SHALL remain in controller_sequencer.

Verification
REQ-033 Reset then 6 edges with opcode=4'h0: CON sequence 5E3, BE3, 263, 1A3, 2C3, 3E3, and tstate returns to 000001.
REQ-034 ADD, then SUB, back to back: T5 = 2E1 for both; T6 = 3C7 then 3CF.
REQ-035 Opcode=4'hF: at T4, HLT=1 and CON=3E3; the state stays HALT for 20 edges; CLR=1 for one edge gives T1, HLT=0 and CON=5E3.
REQ-036 CLR asserted during T5 of ADD: the next state is T1 with CON=5E3, and no T6 word (3C7) appears.
REQ-037 Opcode=4'h7 (undefined): T4–T6 = 3E3, then T1 resumes.
REQ-038 Random opcodes over 1000 cycles: the assertion on REQ-023 holds, and tstate is always one-hot or (in HALT) all-zero.
